// File: rtl/alu_reservation_station_if.sv
// Bundle of the ALU reservation station's issue, CDB and dispatch signals.
//   master : issue stage / CDB / ALU side. It drives the op, the broadcast, rollback and ex_ready.
//   slave  : reservation station. It drives issue_ready, free_count and the ex_* dispatch register.
interface alu_reservation_station_if #(
   parameter int unsigned ENTRY_NUM       = 4,
   parameter int unsigned ROB_ENTRY_WIDTH = 3,
   parameter int unsigned ALUCTRL_WIDTH   = 4
);
   localparam int unsigned CNT_WIDTH = $clog2(ENTRY_NUM + 1);

   logic                       rollback;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [ALUCTRL_WIDTH-1:0]   issue_alu_ctrl;
   logic                       issue_rdy1;
   logic [31:0]                issue_data1;
   logic [ROB_ENTRY_WIDTH-1:0] issue_tag1;
   logic                       issue_rdy2;
   logic [31:0]                issue_data2;
   logic [ROB_ENTRY_WIDTH-1:0] issue_tag2;
   logic [ROB_ENTRY_WIDTH-1:0] issue_rob_index;
   logic                       cdb_valid;
   logic [ROB_ENTRY_WIDTH-1:0] cdb_rob_index;
   logic [31:0]                cdb_data;
   logic                       ex_valid;
   logic                       ex_ready;
   logic [ALUCTRL_WIDTH-1:0]   ex_alu_ctrl;
   logic [31:0]                ex_op1;
   logic [31:0]                ex_op2;
   logic [ROB_ENTRY_WIDTH-1:0] ex_rob_index;
   logic [CNT_WIDTH-1:0]       free_count;

   modport master (
      output rollback, issue_valid, issue_alu_ctrl, issue_rdy1, issue_data1, issue_tag1,
             issue_rdy2, issue_data2, issue_tag2, issue_rob_index,
             cdb_valid, cdb_rob_index, cdb_data, ex_ready,
      input  issue_ready, ex_valid, ex_alu_ctrl, ex_op1, ex_op2, ex_rob_index, free_count
   );

   modport slave (
      input  rollback, issue_valid, issue_alu_ctrl, issue_rdy1, issue_data1, issue_tag1,
             issue_rdy2, issue_data2, issue_tag2, issue_rob_index,
             cdb_valid, cdb_rob_index, cdb_data, ex_ready,
      output issue_ready, ex_valid, ex_alu_ctrl, ex_op1, ex_op2, ex_rob_index, free_count
   );
endinterface

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station for the integer ALU.
// Buffers issued ops until both operands are available, snoops the CDB to wake up pending
// operands, and dispatches one ready op per cycle into a registered ALU dispatch stage.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   rs  : slave side of alu_reservation_station_if. It carries the issue bus, the CDB,
//         rollback, the ex_* dispatch bus and free_count.
module alu_reservation_station #(
   parameter int unsigned ENTRY_NUM       = 4,
   parameter int unsigned ROB_ENTRY_WIDTH = 3,
   parameter int unsigned ALUCTRL_WIDTH   = 4
) (
   input logic                      clk,
   input logic                      rst,
   alu_reservation_station_if.slave rs
);
   localparam int unsigned IDX_WIDTH = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
   localparam int unsigned CNT_WIDTH = $clog2(ENTRY_NUM + 1);

   logic [ENTRY_NUM-1:0]       valid_q;
   logic [ENTRY_NUM-1:0]       rdy1_q;
   logic [ENTRY_NUM-1:0]       rdy2_q;
   logic [ALUCTRL_WIDTH-1:0]   alu_ctrl_q  [ENTRY_NUM];
   logic [31:0]                data1_q     [ENTRY_NUM];
   logic [31:0]                data2_q     [ENTRY_NUM];
   logic [ROB_ENTRY_WIDTH-1:0] tag1_q      [ENTRY_NUM];
   logic [ROB_ENTRY_WIDTH-1:0] tag2_q      [ENTRY_NUM];
   logic [ROB_ENTRY_WIDTH-1:0] rob_index_q [ENTRY_NUM];

   logic                       ex_valid_q;
   logic [ALUCTRL_WIDTH-1:0]   ex_alu_ctrl_q;
   logic [31:0]                ex_op1_q;
   logic [31:0]                ex_op2_q;
   logic [ROB_ENTRY_WIDTH-1:0] ex_rob_index_q;

   logic                 free_found;
   logic [IDX_WIDTH-1:0] free_idx;
   logic                 sel_found;
   logic [IDX_WIDTH-1:0] sel_idx;
   logic [CNT_WIDTH-1:0] free_cnt;
   logic                 issue_ready;
   logic                 issue_fire;
   logic                 ex_load;
   logic                 fwd1;
   logic                 fwd2;

   // Priority encoders and the free-slot count look only at registered state. A slot that is
   // freed by a dispatch cannot be refilled in the same cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      free_cnt   = '0;
      // The loop runs downward, so the lowest matching index is written last and wins.
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_WIDTH'(i);
         end
         if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_WIDTH'(i);
         end
      end
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (!valid_q[i]) free_cnt = free_cnt + CNT_WIDTH'(1);
      end
   end

   assign issue_ready = free_found;
   assign issue_fire  = rs.issue_valid & issue_ready;
   assign ex_load     = (!ex_valid_q | rs.ex_ready) & sel_found;
   // An operand that is broadcast in the same cycle as it is issued is captured here.
   // Without this capture, the entry would wait forever for a tag that has already gone by.
   assign fwd1 = !rs.issue_rdy1 & rs.cdb_valid & (rs.cdb_rob_index == rs.issue_tag1);
   assign fwd2 = !rs.issue_rdy2 & rs.cdb_valid & (rs.cdb_rob_index == rs.issue_tag2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q        <= '0;
         rdy1_q         <= '0;
         rdy2_q         <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            alu_ctrl_q[i]  <= '0;
            data1_q[i]     <= '0;
            data2_q[i]     <= '0;
            tag1_q[i]      <= '0;
            tag2_q[i]      <= '0;
            rob_index_q[i] <= '0;
         end
         ex_valid_q     <= 1'b0;
         ex_alu_ctrl_q  <= '0;
         ex_op1_q       <= '0;
         ex_op2_q       <= '0;
         ex_rob_index_q <= '0;
      end else if (rs.rollback) begin
         valid_q    <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         // CDB wakeup of pending operands.
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (valid_q[i] && rs.cdb_valid) begin
               if (!rdy1_q[i] && (tag1_q[i] == rs.cdb_rob_index)) begin
                  data1_q[i] <= rs.cdb_data;
                  rdy1_q[i]  <= 1'b1;
               end
               if (!rdy2_q[i] && (tag2_q[i] == rs.cdb_rob_index)) begin
                  data2_q[i] <= rs.cdb_data;
                  rdy2_q[i]  <= 1'b1;
               end
            end
         end

         if (ex_load) begin
            valid_q[sel_idx] <= 1'b0;
            ex_valid_q       <= 1'b1;
            ex_alu_ctrl_q    <= alu_ctrl_q[sel_idx];
            ex_op1_q         <= data1_q[sel_idx];
            ex_op2_q         <= data2_q[sel_idx];
            ex_rob_index_q   <= rob_index_q[sel_idx];
         end else if (rs.ex_ready) begin
            ex_valid_q <= 1'b0;
         end

         // The issue target is always an invalid slot, so it can never be the dispatched slot.
         if (issue_fire) begin
            valid_q[free_idx]     <= 1'b1;
            alu_ctrl_q[free_idx]  <= rs.issue_alu_ctrl;
            rdy1_q[free_idx]      <= rs.issue_rdy1 | fwd1;
            data1_q[free_idx]     <= fwd1 ? rs.cdb_data : rs.issue_data1;
            tag1_q[free_idx]      <= rs.issue_tag1;
            rdy2_q[free_idx]      <= rs.issue_rdy2 | fwd2;
            data2_q[free_idx]     <= fwd2 ? rs.cdb_data : rs.issue_data2;
            tag2_q[free_idx]      <= rs.issue_tag2;
            rob_index_q[free_idx] <= rs.issue_rob_index;
         end
      end
   end

   assign rs.issue_ready  = issue_ready;
   assign rs.free_count   = free_cnt;
   assign rs.ex_valid     = ex_valid_q;
   assign rs.ex_alu_ctrl  = ex_alu_ctrl_q;
   assign rs.ex_op1       = ex_op1_q;
   assign rs.ex_op2       = ex_op2_q;
   assign rs.ex_rob_index = ex_rob_index_q;
endmodule
